// File: rtl/adc_spi_pkg.sv
// Shared types and derived sizes for the multi-channel serial ADC capture engine.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2
    } state_t;

    // Shortest cs_n-fall to cs_n-fall spacing: full frame, quiet gap, one idle cycle.
    function automatic int p_min(input int frame_bits, input int half_div, input int quiet_cyc);
        return (2 * frame_bits + 1) * half_div + quiet_cyc + 1;
    endfunction

    function automatic int h_width(input int frame_bits);
        return $clog2(2 * frame_bits + 1);
    endfunction

    function automatic int div_width(input int half_div);
        return (half_div > 1) ? $clog2(half_div) : 1;
    endfunction

endpackage

// File: rtl/adc_spi_array_rx_if.sv
// Result stream from the capture engine toward the sample FIFO / DSP chain.
interface adc_spi_array_rx_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 12
);
    logic                     valid;
    logic                     ready;
    logic                     overrun;
    logic [N_CH*DATA_W-1:0]   data;

    modport master (output valid, output data, output overrun, input ready);
    modport slave  (input valid, input data, input overrun, output ready);
endinterface

// File: rtl/adc_shift_lane.sv
// One channel's MSB-first shift register; word_next already includes the bit being sampled.
module adc_shift_lane #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic              sdo,
    output logic [DATA_W-1:0] word_next
);

    logic [DATA_W-1:0] sh;

    generate
        if (DATA_W == 1) begin : g_one
            assign word_next = shift ? sdo : sh;
        end else begin : g_multi
            assign word_next = shift ? {sh[DATA_W-2:0], sdo} : sh;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) sh <= '0;
        else        sh <= word_next;
    end

endmodule

// File: rtl/adc_spi_array_rx.sv
// Capture engine for a bank of simultaneously sampled CS/SCLK/SDO ADCs.
// state | meaning
// IDLE  | cs_n high, waiting for start or continuous-period expiry
// CONV  | cs_n low, stepping half-periods h = 0..2*FRAME_BITS
// QUIET | cs_n high for QUIET_CYC cycles before the next frame may start
module adc_spi_array_rx
    import adc_spi_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DATA_W     = 12,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 2,
    parameter int HALF_DIV   = 2,
    parameter int QUIET_CYC  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cont,
    input  logic [15:0]            period,
    output logic                   cs_n,
    output logic                   sclk,
    input  logic [N_CH-1:0]        sdo,
    output logic                   busy,
    adc_spi_array_rx_if.master     res
);

    localparam int HW = h_width(FRAME_BITS);
    localparam int DW = div_width(HALF_DIV);
    localparam int QW = div_width(QUIET_CYC);

    localparam logic [HW-1:0] H_LAST   = HW'(2 * FRAME_BITS);
    localparam logic [HW-1:0] WIN_LO   = HW'(2 * LEAD_BITS + 2);
    localparam logic [HW-1:0] WIN_HI   = HW'(2 * (LEAD_BITS + DATA_W - 1) + 2);
    localparam logic [DW-1:0] DIV_LOAD = DW'(HALF_DIV - 1);
    localparam logic [QW-1:0] Q_LOAD   = QW'(QUIET_CYC - 1);
    localparam logic [15:0]   PMIN     = 16'(p_min(FRAME_BITS, HALF_DIV, QUIET_CYC));

    state_t                 state;
    logic [HW-1:0]          h;
    logic [DW-1:0]          div;
    logic [QW-1:0]          qcnt;
    logic [15:0]            tmr;
    logic                   div_tc;
    logic                   sample_en;
    logic                   go;
    logic [15:0]            per_eff;
    logic [N_CH*DATA_W-1:0] frame_word;

    always_comb begin
        div_tc    = (div == '0);
        // Bit k is taken at the end of even half-period h = 2k+2, only inside the data window.
        sample_en = (state == ST_CONV) && div_tc && !h[0] && (h >= WIN_LO) && (h <= WIN_HI);
        go        = start || (cont && (tmr == '0));
        per_eff   = (period > PMIN) ? period : PMIN;
    end

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_lane
            adc_shift_lane #(.DATA_W(DATA_W)) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .shift     (sample_en),
                .sdo       (sdo[c]),
                .word_next (frame_word[c*DATA_W +: DATA_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            h           <= '0;
            div         <= '0;
            qcnt        <= '0;
            tmr         <= '0;
            cs_n        <= 1'b1;
            sclk        <= 1'b1;
            busy        <= 1'b0;
            res.valid   <= 1'b0;
            res.overrun <= 1'b0;
            res.data    <= '0;
        end else begin
            if (tmr != '0) tmr <= tmr - 1'b1;

            if (res.valid && res.ready) begin
                res.valid   <= 1'b0;
                res.overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_CONV;
                        cs_n  <= 1'b0;
                        busy  <= 1'b1;
                        h     <= '0;
                        div   <= DIV_LOAD;
                        // Timer expires on the cycle before the next cs_n fall is due.
                        tmr   <= per_eff - 1'b1;
                    end
                end
                ST_CONV: begin
                    if (!div_tc) begin
                        div <= div - 1'b1;
                    end else if (h == H_LAST) begin
                        state       <= ST_QUIET;
                        cs_n        <= 1'b1;
                        sclk        <= 1'b1;
                        qcnt        <= Q_LOAD;
                        res.data    <= frame_word;
                        res.valid   <= 1'b1;
                        res.overrun <= res.valid && !res.ready;
                    end else begin
                        h    <= h + 1'b1;
                        div  <= DIV_LOAD;
                        sclk <= h[0];
                    end
                end
                ST_QUIET: begin
                    if (qcnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        qcnt <= qcnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/adc_spi_array_rx.md
# adc_spi_array_rx

Parametrised capture engine for a bank of serial ADCs (ADS7883-class, CS/SCLK/SDO), supporting any number of simultaneously sampled channels, frame length, data width, SCLK rate and free-running conversion. All channels share `cs_n` and `sclk`; each channel has its own `sdo` line. Results are presented on one valid/ready stream toward the downstream sample FIFO or DSP chain.

## Interface
- `N_CH`, 2: number of ADC channels (≥1).
- `DATA_W`, 12: result bits per channel.
- `FRAME_BITS`, 16: SCLK periods per frame.
- `LEAD_BITS`, 2: bits discarded before the MSB. Constraint: `LEAD_BITS+DATA_W ≤ FRAME_BITS`.
- `HALF_DIV`, 2: clk cycles per SCLK half-period (≥1).
- `QUIET_CYC`, 3: clk cycles `cs_n` stays high after a frame, before the next frame may start (≥1).
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-shot request, sampled in IDLE only.
- `cont` in 1: continuous-conversion enable.
- `period` in 16: clk cycles between `cs_n` falling edges in continuous mode.
- `cs_n` out 1: shared chip select.
- `sclk` out 1: shared serial clock, idles high.
- `sdo` in N_CH: per-channel serial data.
- `busy` out 1: high from the cycle `cs_n` falls until QUIET ends.
- `valid` out 1: result available.
- `ready` in 1: downstream accept.
- `data` out N_CH*DATA_W: channel c in bits `[c*DATA_W +: DATA_W]`.
- `overrun` out 1: the held result overwrote an unaccepted result.

## Operation
- FSM states: IDLE → CONV → QUIET → IDLE.
- IDLE: `cs_n=1`, `sclk=1`. Leave on `start`, or on `cont` with the period timer expired.
- CONV: half-period index h = 0..2·FRAME_BITS. Each h lasts HALF_DIV cycles.
  - h=0: `sclk` high (CS setup).
  - Odd h: `sclk` low. Even h≥2: `sclk` high.
  - Bit k (k = 0..FRAME_BITS-1) is sampled on every `sdo` at the last clk cycle of h = 2k+2, i.e. just before the next falling edge.
  - Bits k in [LEAD_BITS, LEAD_BITS+DATA_W-1] are shifted in MSB-first; all other bits are ignored.
- End of CONV: `cs_n` rises, `sclk` stays high, and the shift registers load `data`. `valid` is set in the same cycle. Enter QUIET for QUIET_CYC cycles.
- `start` while not IDLE: ignored (no queueing).
- Continuous mode:
  - `period` is sampled when `cs_n` falls.
  - The next frame starts `max(period, P_MIN)` cycles after the previous `cs_n` fall, where `P_MIN = (2·FRAME_BITS+1)·HALF_DIV + QUIET_CYC + 1`.
  - Deasserting `cont` mid-frame: the current frame completes and no further frame starts.
- Output stream:
  - `data` is stable while `valid` and not `ready`.
  - A frame completing while `valid & ~ready`: `data` is overwritten, `valid` stays 1, `overrun` is set.
  - `overrun` clears on the `valid & ready` handshake.
  - Completion in the same cycle as `valid & ready`: new data is loaded, `valid` stays 1, `overrun` is not set.

## Timing
- Reset values: `cs_n=1`, `sclk=1`, `busy=0`, `valid=0`, `overrun=0`, `data=0`. FSM → IDLE, counters cleared.
- Reset mid-frame: the outputs above take effect on the first reset edge. No partial result is emitted.
- Single shot, `start` at cycle 0:
  - `cs_n` low from cycle 1.
  - First `sclk` fall at cycle 1+HALF_DIV.
  - `cs_n` high and `valid` high at cycle L = 1+(2·FRAME_BITS+1)·HALF_DIV (67 with defaults).
  - IDLE at L+QUIET_CYC. Earliest next `start` is accepted at that cycle (P_MIN = 70 with defaults).
- Exactly FRAME_BITS falling edges of `sclk` occur per frame.
- All outputs are registered; no combinational path from `sdo`/`ready` to outputs.

## Structure
- Package `adc_spi_pkg`:
  - state enum (IDLE/CONV/QUIET);
  - function computing P_MIN;
  - function computing counter widths (`$clog2(2·FRAME_BITS+1)`, `$clog2(HALF_DIV)`).
- Sub-module `adc_shift_lane` (DATA_W shift register with window enable), one instance per channel via generate. Divider, h counter, period timer and FSM live in the top.

## Test plan
Defaults throughout (N_CH=2, DATA_W=12, FRAME_BITS=16, LEAD_BITS=2, HALF_DIV=2, QUIET_CYC=3). Each `sdo` is driven by an ADC model that changes on the `sclk` falling edge.

- **Single shot:** ch0 = 0xA5C, ch1 = 0x3F0, `start` at cycle 0 → `cs_n` low cycles 1..66, 16 `sclk` falls, `valid=1` at cycle 67, `data = {0x3F0, 0xA5C}`, `busy` drops at cycle 70.
- **Window:** model drives 1s in lead and trailing bits with data 0x000 → `data = 0`.
- **Backpressure:** `ready=0`, two frames (0x111, then 0x222) → `data` shows 0x222, `overrun=1`. Then `ready=1` for one cycle → `valid=0`, `overrun=0`. A completion coincident with the handshake → `valid` stays 1, `overrun=0`.
- **Continuous:** `cont=1`, `period=100` → `cs_n` falls every 100 cycles. `period=10` → every 70 cycles. `cont` dropped mid-frame → that frame completes, no further `cs_n` fall.
- **Ignored start:** `start` pulsed at cycle 30 of a frame → no extra frame, timing unchanged.
- **Reset mid-frame:** `rst_n` low at cycle 40 → next cycle `cs_n=1`, `sclk=1`, `valid=0`, `data=0`. A subsequent `start` produces a correct frame.
